// File: rtl/sipo_frame_receiver.sv
// Serial-in, parallel-out frame receiver: assembles WIDTH-bit words aligned by frame_start and
// presents them through a one-entry valid/ready buffer with sticky overrun and framing-error pulse.
module sipo_frame_receiver #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             frame_start,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~overrun_clr;
        ferr_d    = 1'b0;
        complete  = 1'b0;

        // A frame_start bit always begins from an empty register so no stale bits survive.
        shift_base = frame_start ? '0 : shreg_q;
        if (MSB_FIRST) begin
            shifted = {shift_base[WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, shift_base[WIDTH-1:1]};
        end

        unique case (state_q)
            StIdle: begin
                if (shift && frame_start) begin
                    shreg_d = shifted;
                    cnt_d   = CntOne;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (shift) begin
                    shreg_d = shifted;
                    if (frame_start) begin
                        ferr_d = 1'b1;
                        cnt_d  = CntOne;
                    end else if (cnt_q == CntLast) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A drain in the same cycle frees the buffer for the new word.
        if (complete) begin
            if (!valid_q || out_ready) begin
                pout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;
    assign frame_error  = ferr_q;
    assign busy         = (state_q == StRecv);

endmodule
